// File: rtl/ring_buf_pkg.sv
// Shared defaults for the ring buffer: entry geometry, depth,
// and the helper that sizes the occupancy counter.
package ring_buf_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_CHANNELS = 2;
   localparam int DEF_DEPTH    = 4;

   // Counter must hold 0..depth inclusive, hence one extra bit.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ring_buf_reg_if.sv
// Storage bus between the pointer logic and the entry memory.
// master: we/waddr/wdata/raddr out, rdata in; slave: the reverse.
interface ring_buf_reg_if #(
   parameter int DW = 64,
   parameter int AW = 2
);

   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;

   modport master (
      output we, waddr, wdata, raddr,
      input  rdata
   );

   modport slave (
      input  we, waddr, wdata, raddr,
      output rdata
   );

endinterface

// File: rtl/ring_buf_mem.sv
// Entry storage: DEPTH x DW, one synchronous write, one async read.
// Ports: clk, bus (slave side of the storage bus). No reset.
module ring_buf_mem #(
   parameter int DW    = 64,
   parameter int DEPTH = 4
) (
   input logic            clk,
   ring_buf_reg_if.slave  bus
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (bus.we) mem[bus.waddr] <= bus.wdata;
   end

   assign bus.rdata = mem[bus.raddr];

endmodule

// File: rtl/ring_buf_reg.sv
// Ring buffer with show-ahead head, sticky error flags, optional
// drop-oldest mode. Ports: Clk, Reset (async low), write/in_data,
// read, clear_err, out_data, flag, full, count, overflow, underflow.
module ring_buf_reg
   import ring_buf_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int OVERWRITE = 0
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        write,
   input  logic [CHANNELS*WIDTH-1:0]   in_data,
   input  logic                        read,
   input  logic                        clear_err,
   output logic [CHANNELS*WIDTH-1:0]   out_data,
   output logic                        flag,
   output logic                        full,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int DW = CHANNELS * WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] cnt;

   logic is_empty;
   logic is_full;
   logic ow;
   logic push;
   logic pop;
   logic drop;
   logic adv_rp;
   logic ovf_set;
   logic unf_set;

   ring_buf_reg_if #(.DW(DW), .AW(AW)) bus ();

   ring_buf_mem #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk (Clk),
      .bus (bus)
   );

   // Status comes only from registered count.
   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == CW'(DEPTH));
   assign ow       = (OVERWRITE != 0);

   // A push at full proceeds if a pop frees the slot in the
   // same edge, or if drop-oldest mode evicts the head.
   assign push    = write & (~is_full | read | ow);
   assign pop     = read & ~is_empty;
   assign drop    = write & ~read & is_full & ow;
   assign adv_rp  = pop | drop;
   assign ovf_set = write & ~read & is_full;
   assign unf_set = read & is_empty;

   assign bus.we    = push;
   assign bus.waddr = wp;
   assign bus.wdata = in_data;
   assign bus.raddr = rp;

   // Stale storage is masked while empty, including under reset.
   assign out_data = is_empty ? '0 : bus.rdata;
   assign flag     = ~is_empty;
   assign full     = is_full;
   assign count    = cnt;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push)   wp <= wp + AW'(1);
         if (adv_rp) rp <= rp + AW'(1);
         unique case ({push, adv_rp})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         // A fresh error wins over a simultaneous clear.
         overflow  <= ovf_set | (overflow  & ~clear_err);
         underflow <= unf_set | (underflow & ~clear_err);
      end
   end

endmodule

// File: tb/tb_ring_buf_reg.sv
// Directed bench for ring_buf_reg: one keep-on-full and one
// drop-oldest instance driven by the same stimulus.
module tb_ring_buf_reg;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic        clear_err = 1'b0;
   logic [63:0] in_data = '0;

   logic [63:0] out0, out1;
   logic        flag0, flag1;
   logic        full0, full1;
   logic [2:0]  cnt0, cnt1;
   logic        ovf0, ovf1;
   logic        unf0, unf1;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   ring_buf_reg #(.OVERWRITE(0)) dut0 (
      .Clk       (Clk),
      .Reset     (Reset),
      .write     (write),
      .in_data   (in_data),
      .read      (read),
      .clear_err (clear_err),
      .out_data  (out0),
      .flag      (flag0),
      .full      (full0),
      .count     (cnt0),
      .overflow  (ovf0),
      .underflow (unf0)
   );

   ring_buf_reg #(.OVERWRITE(1)) dut1 (
      .Clk       (Clk),
      .Reset     (Reset),
      .write     (write),
      .in_data   (in_data),
      .read      (read),
      .clear_err (clear_err),
      .out_data  (out1),
      .flag      (flag1),
      .full      (full1),
      .count     (cnt1),
      .overflow  (ovf1),
      .underflow (unf1)
   );

   function automatic logic [63:0] ent(input int v);
      return {32'(v + 256), 32'(v)};
   endfunction

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      write = 1'b0;
      read = 1'b0;
      clear_err = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_count", 64'(cnt0), 64'd0);
      chk("rst_flag", 64'(flag0), 64'd0);
      chk("rst_full", 64'(full0), 64'd0);
      chk("rst_out", out0, 64'd0);
      chk("rst_ovf", 64'(ovf0), 64'd0);
      chk("rst_unf", 64'(unf0), 64'd0);
      Reset = 1'b1;

      // two-channel push/pop
      write = 1'b1;
      in_data = {32'hB1, 32'hA1};
      tick();
      chk("p1_flag", 64'(flag0), 64'd1);
      chk("p1_count", 64'(cnt0), 64'd1);
      chk("p1_out", out0, {32'hB1, 32'hA1});
      in_data = {32'hB2, 32'hA2};
      tick();
      idle();
      chk("p2_count", 64'(cnt0), 64'd2);
      chk("p2_out", out0, {32'hB1, 32'hA1});
      read = 1'b1;
      tick();
      idle();
      chk("pop_out", out0, {32'hB2, 32'hA2});
      chk("pop_count", 64'(cnt0), 64'd1);
      read = 1'b1;
      tick();
      idle();
      chk("empty_out", out0, 64'd0);
      chk("empty_flag", 64'(flag0), 64'd0);

      // push 1..5 into both modes
      Reset = 1'b0;
      #1;
      Reset = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         write = 1'b1;
         in_data = ent(i);
         tick();
      end
      idle();
      chk("ow0_full", 64'(full0), 64'd1);
      chk("ow0_count", 64'(cnt0), 64'd4);
      chk("ow0_ovf", 64'(ovf0), 64'd1);
      chk("ow0_out", out0, ent(1));
      chk("ow1_count", 64'(cnt1), 64'd4);
      chk("ow1_ovf", 64'(ovf1), 64'd1);
      chk("ow1_out", out1, ent(2));
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("drain0_%0d", k), out0, ent(k));
         chk($sformatf("drain1_%0d", k), out1, ent(k + 1));
         read = 1'b1;
         tick();
      end
      idle();
      chk("drain0_flag", 64'(flag0), 64'd0);
      chk("drain1_flag", 64'(flag1), 64'd0);

      // simultaneous push/pop on empty
      write = 1'b1;
      read = 1'b1;
      in_data = ent(7);
      tick();
      idle();
      chk("wr_empty_count", 64'(cnt0), 64'd1);
      chk("wr_empty_out", out0, ent(7));
      chk("wr_empty_unf", 64'(unf0), 64'd1);
      chk("wr_empty_unf1", 64'(unf1), 64'd1);
      clear_err = 1'b1;
      tick();
      idle();
      chk("clr_unf", 64'(unf0), 64'd0);
      chk("clr_ovf", 64'(ovf0), 64'd0);
      chk("clr_count", 64'(cnt0), 64'd1);

      // fill, then 10 cycles of push+pop at full
      for (int i = 8; i <= 10; i++) begin
         write = 1'b1;
         in_data = ent(i);
         tick();
      end
      idle();
      chk("fill_full", 64'(full0), 64'd1);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("wrap_head_%0d", c), out0, ent(7 + c));
         chk($sformatf("wrap_head1_%0d", c), out1, ent(7 + c));
         write = 1'b1;
         read = 1'b1;
         in_data = ent(11 + c);
         tick();
         chk($sformatf("wrap_count_%0d", c), 64'(cnt0), 64'd4);
         chk($sformatf("wrap_ovf_%0d", c), 64'(ovf0), 64'd0);
      end
      idle();
      chk("wrap_out", out0, ent(17));
      chk("wrap_ovf1", 64'(ovf1), 64'd0);

      // async reset mid-operation
      Reset = 1'b0;
      #1;
      Reset = 1'b1;
      read = 1'b1;
      tick();
      idle();
      chk("pre_unf", 64'(unf0), 64'd1);
      for (int i = 30; i < 33; i++) begin
         write = 1'b1;
         in_data = ent(i);
         tick();
      end
      idle();
      chk("pre_count", 64'(cnt0), 64'd3);
      #2;
      Reset = 1'b0;
      #1;
      chk("ar_count", 64'(cnt0), 64'd0);
      chk("ar_flag", 64'(flag0), 64'd0);
      chk("ar_full", 64'(full0), 64'd0);
      chk("ar_out", out0, 64'd0);
      chk("ar_ovf", 64'(ovf0), 64'd0);
      chk("ar_unf", 64'(unf0), 64'd0);
      #1;
      Reset = 1'b1;
      write = 1'b1;
      in_data = ent(42);
      tick();
      idle();
      chk("post_count", 64'(cnt0), 64'd1);
      chk("post_out", out0, ent(42));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
